// File: rtl/alu_div_unit_if.sv
// Request/response bundle between the execute-stage control and the divider.
interface alu_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;

  // Requester side: issues operands, observes results.
  modport master (
    output start_i, signed_i, dividend_i, divisor_i,
    input  busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );

  // Divider side.
  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i,
    output busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );
endinterface

// File: rtl/alu_div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// sign correction applied when the result is written.
module alu_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_div_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_prem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Operand capture: magnitudes and sign flags (most negative value keeps its bit pattern = 2^(W-1)).
  assign w_accept = bus.start_i && (r_state != ST_RUN);
  assign w_a_neg  = bus.signed_i && bus.dividend_i[WIDTH-1];
  assign w_b_neg  = bus.signed_i && bus.divisor_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? WIDTH'(-bus.dividend_i) : bus.dividend_i;
  assign w_b_mag  = w_b_neg ? WIDTH'(-bus.divisor_i) : bus.divisor_i;

  // One restoring step; a set top bit of the shifted remainder already exceeds any divisor.
  assign w_shift    = {r_prem, r_dvd[WIDTH-1]};
  assign w_sub      = w_shift - {1'b0, r_dsr};
  assign w_ge       = w_shift[WIDTH] || !w_sub[WIDTH];
  assign w_prem_nxt = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt  = {r_dvd[WIDTH-2:0], w_ge};

  // Sign correction on the final step: truncation toward zero.
  assign w_quo_fix = r_neg_q ? WIDTH'(-w_quo_nxt) : w_quo_nxt;
  assign w_rem_fix = r_neg_r ? WIDTH'(-w_prem_nxt) : w_prem_nxt;

  // Control FSM, datapath and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_prem  <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_prem <= w_prem_nxt;
          r_dvd  <= w_quo_nxt;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quo   <= w_quo_fix;
            r_rem   <= w_rem_fix;
          end
        end
        default: begin
          if (w_accept) begin
            r_dz <= 1'b0;
            if (bus.divisor_i == '0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_quo   <= '1;
              r_rem   <= bus.dividend_i;
              r_dz    <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
              r_cnt   <= CNT_W'(WIDTH - 1);
              r_prem  <= '0;
              r_dvd   <= w_a_mag;
              r_dsr   <= w_b_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.quotient_o  = r_quo;
  assign bus.remainder_o = r_rem;
  assign bus.div_zero_o  = r_dz;

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed scoreboard bench for alu_div_unit.
module tb_alu_div_unit;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];

  alu_div_unit_if #(.WIDTH(32)) bus ();

  alu_div_unit #(.WIDTH(32)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("quotient", bus.quotient_o, e.q);
        chk("remainder", bus.remainder_o, e.r);
        chk("div_zero", 32'(bus.div_zero_o), 32'(e.dz));
      end
    end
  end

  // Called at a negedge; start is seen by exactly one rising edge.
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic [31:0] eq, input logic [31:0] er,
                          input logic edz);
    exp_t e;
    bus.start_i    = 1'b1;
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    e.q = eq; e.r = er; e.dz = edz;
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
  endtask

  // Counts cycles to done and busy cycles; optionally injects a start mid-RUN and checks held results.
  task automatic wait_done(input string name, input int exp_lat, input int exp_busy,
                           input logic inject, input logic hold_chk, input logic [31:0] hold_q);
    int lat;
    int busy_n;
    logic got;
    lat = 0; busy_n = 0; got = 1'b0;
    while (lat < 40 && !got) begin
      @(negedge clk);
      lat++;
      if (bus.busy_o) busy_n++;
      if (hold_chk && lat == 2) chk({name, "_held_q"}, bus.quotient_o, hold_q);
      if (inject && lat == 10) begin
        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'd77;
        bus.divisor_i  = 32'd0;
      end else if (inject && lat == 11) begin
        bus.start_i = 1'b0;
      end
      if (bus.done_o) got = 1'b1;
    end
    chk({name, "_got_done"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
  endtask

  initial begin
    int dones;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    // Reset must win over a pending zero-divide start.
    bus.start_i    = 1'b1;
    bus.signed_i   = 1'b0;
    bus.dividend_i = 32'h12345678;
    bus.divisor_i  = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_quotient", bus.quotient_o, 32'd0);
    chk("rst_remainder", bus.remainder_o, 32'd0);
    chk("rst_div_zero", 32'(bus.div_zero_o), 32'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);

    start_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
    wait_done("u100_7", 33, 32, 1'b0, 1'b0, 32'd0);
    start_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    wait_done("s_m7_2", 33, 32, 1'b0, 1'b0, 32'd0);
    start_op(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
    wait_done("s_7_m2", 33, 32, 1'b0, 1'b0, 32'd0);
    start_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
    wait_done("s_ovf", 33, 32, 1'b0, 1'b0, 32'd0);
    start_op(1'b0, 32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    wait_done("u_dz", 1, 0, 1'b0, 1'b0, 32'd0);
    start_op(1'b1, 32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1);
    wait_done("s_dz", 1, 0, 1'b0, 1'b0, 32'd0);
    start_op(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0);
    wait_done("u_max_1", 33, 32, 1'b0, 1'b0, 32'd0);
    start_op(1'b0, 32'd5, 32'hFFFFFFFF, 1'b1, 32'd0, 32'd5, 1'b0);
    wait_done("u_5_max", 33, 32, 1'b0, 1'b0, 32'd0);

    // Start during RUN is ignored; a wrongly accepted zero-divide would end early.
    start_op(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
    wait_done("ignore", 33, 32, 1'b1, 1'b0, 32'd0);

    // Back-to-back: second start issued in the DONE cycle.
    start_op(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, 1'b0);
    wait_done("b2b_first", 33, 32, 1'b0, 1'b0, 32'd0);
    start_op(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    wait_done("b2b_second", 33, 32, 1'b0, 1'b1, 32'd100);

    // Reset in the middle of an operation: no done, outputs cleared.
    start_op(1'b0, 32'd50, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy_o), 32'd0);
    chk("midrst_done", 32'(bus.done_o), 32'd0);
    chk("midrst_quotient", bus.quotient_o, 32'd0);
    chk("midrst_remainder", bus.remainder_o, 32'd0);
    chk("midrst_div_zero", 32'(bus.div_zero_o), 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    start_op(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0);
    wait_done("after_rst", 33, 32, 1'b0, 1'b0, 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
